// File: rtl/vector_checker_pkg.sv
// Shared definitions for the in-fabric vector checker: default widths,
// settle time and the run-state encoding.
package vector_checker_pkg;

    localparam int STIM_W_DEF = 2;
    localparam int RESP_W_DEF = 1;
    localparam int DEPTH_DEF  = 16;
    localparam int ADDR_W_DEF = 4;
    localparam int SETTLE_DEF = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic is_busy_state(input state_t s);
        return (s == ST_LOAD) || (s == ST_WAIT) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/vector_mem.sv
// Vector store: one stimulus/expected pair per entry, written synchronously
// and read combinationally. Contents survive reset on purpose.
module vector_mem
    import vector_checker_pkg::*;
#(
    parameter int STIM_W = STIM_W_DEF,
    parameter int RESP_W = RESP_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [STIM_W-1:0] i_wr_stim,
    input  logic [RESP_W-1:0] i_wr_exp,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [STIM_W-1:0] o_rd_stim,
    output logic [RESP_W-1:0] o_rd_exp
);

    logic [STIM_W-1:0] r_stim [DEPTH];
    logic [RESP_W-1:0] r_exp  [DEPTH];

    // Write port
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_stim[i_wr_addr] <= i_wr_stim;
            r_exp[i_wr_addr]  <= i_wr_exp;
        end
    end

    assign o_rd_stim = r_stim[i_rd_addr];
    assign o_rd_exp  = r_exp[i_rd_addr];

endmodule

// File: rtl/vector_checker.sv
// Self-test stage: plays stored stimulus into a combinational DUT, waits for
// it to settle, compares the response and records the first mismatch.
module vector_checker
    import vector_checker_pkg::*;
#(
    parameter int STIM_W = STIM_W_DEF,
    parameter int RESP_W = RESP_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [STIM_W-1:0] i_wr_stim,
    input  logic [RESP_W-1:0] i_wr_exp,
    input  logic [ADDR_W:0]   i_num_vec,
    input  logic              i_stop_on_err,
    input  logic              i_start,
    output logic [STIM_W-1:0] o_stim,
    input  logic [RESP_W-1:0] i_resp,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [ADDR_W:0]   o_err_count,
    output logic [ADDR_W-1:0] o_err_addr,
    output logic [RESP_W-1:0] o_err_got,
    output logic [RESP_W-1:0] o_err_exp
);

    localparam int                CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [ADDR_W:0]   DEPTH_L     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ZERO    = {(ADDR_W + 1){1'b0}};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W:0]     r_num;
    logic [CNT_W-1:0]    r_settle;
    logic [STIM_W-1:0]   r_stim;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [ADDR_W:0]     r_err_count;
    logic [ADDR_W-1:0]   r_err_addr;
    logic [RESP_W-1:0]   r_err_got;
    logic [RESP_W-1:0]   r_err_exp;

    logic [ADDR_W:0]     w_num_clamped;
    logic                w_start_ok;
    logic                w_wr_en;
    logic                w_mismatch;
    logic                w_last;
    logic [STIM_W-1:0]   w_rd_stim;
    logic [RESP_W-1:0]   w_rd_exp;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_pass_nxt;
    logic [ADDR_W:0]     w_err_count_nxt;

    assign w_num_clamped = (i_num_vec > DEPTH_L) ? DEPTH_L : i_num_vec;
    assign w_start_ok    = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_wr_en       = i_wr_en && !is_busy_state(r_state);
    assign w_mismatch    = (r_state == ST_CHECK) && (i_resp != w_rd_exp);
    assign w_last        = ({1'b0, r_idx} == (r_num - (ADDR_W + 1)'(1)));

    vector_mem #(
        .STIM_W (STIM_W),
        .RESP_W (RESP_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_stim (i_wr_stim),
        .i_wr_exp  (i_wr_exp),
        .i_rd_addr (r_idx),
        .o_rd_stim (w_rd_stim),
        .o_rd_exp  (w_rd_exp)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; stop_on_err is looked at live in CHECK
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    if (w_num_clamped == CNT_ZERO) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_LOAD;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_LOAD: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (r_settle == SETTLE_LAST) begin
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_CHECK: begin
                if (w_mismatch && i_stop_on_err) begin
                    w_state_nxt = ST_DONE;
                end else if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the status flags can be registered
    always_comb begin
        w_err_count_nxt = r_err_count;
        if (w_start_ok) begin
            w_err_count_nxt = CNT_ZERO;
        end else if (w_mismatch) begin
            w_err_count_nxt = r_err_count + (ADDR_W + 1)'(1);
        end else begin
            w_err_count_nxt = r_err_count;
        end
        w_busy_nxt = is_busy_state(w_state_nxt);
        w_done_nxt = (w_state_nxt == ST_DONE);
        w_pass_nxt = w_done_nxt && (w_err_count_nxt == CNT_ZERO);
    end

    // Datapath: index, settle counter, stimulus and error capture
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_idx       <= {ADDR_W{1'b0}};
            r_num       <= CNT_ZERO;
            r_settle    <= {CNT_W{1'b0}};
            r_stim      <= {STIM_W{1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= CNT_ZERO;
            r_err_addr  <= {ADDR_W{1'b0}};
            r_err_got   <= {RESP_W{1'b0}};
            r_err_exp   <= {RESP_W{1'b0}};
        end else begin
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_err_count <= w_err_count_nxt;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_idx      <= {ADDR_W{1'b0}};
                        r_num      <= w_num_clamped;
                        r_err_addr <= {ADDR_W{1'b0}};
                        r_err_got  <= {RESP_W{1'b0}};
                        r_err_exp  <= {RESP_W{1'b0}};
                    end
                end
                ST_LOAD: begin
                    r_stim   <= w_rd_stim;
                    r_settle <= {CNT_W{1'b0}};
                end
                ST_WAIT: r_settle <= r_settle + CNT_W'(1);
                ST_CHECK: begin
                    if (w_mismatch && (r_err_count == CNT_ZERO)) begin
                        r_err_addr <= r_idx;
                        r_err_got  <= i_resp;
                        r_err_exp  <= w_rd_exp;
                    end
                    if (w_state_nxt == ST_LOAD) begin
                        r_idx <= r_idx + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_stim      = r_stim;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_err_count = r_err_count;
    assign o_err_addr  = r_err_addr;
    assign o_err_got   = r_err_got;
    assign o_err_exp   = r_err_exp;

endmodule

// File: doc/vector_checker.md
Name: vector_checker

Overview:
- Synthesizable self-test stage that sits directly around a small combinational DUT.
- Drives the DUT input from an on-chip vector memory and consumes the DUT output.
- Compares each output against a stored expected value; counts and logs mismatches.
- Replaces file-driven checking with an in-fabric pass/fail checker usable on a board.

Parameters:
- STIM_W, 2, width of stimulus bus driven to the DUT
- RESP_W, 1, width of DUT response
- DEPTH, 16, number of vector entries
- ADDR_W, 4, vector address width; DEPTH <= 2**ADDR_W
- SETTLE, 5, cycles allowed for the DUT output to settle before sampling; must be >= 1

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write one vector entry; honoured only when busy=0
- wr_addr  in  ADDR_W  entry index
- wr_stim  in  STIM_W  stimulus to store
- wr_exp  in  RESP_W  expected response to store
- num_vec  in  ADDR_W+1  number of vectors to run; clamped to DEPTH
- stop_on_err  in  1  1 = halt at first mismatch
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE
- stim  out  STIM_W  registered stimulus to DUT
- resp  in  RESP_W  DUT response
- busy  out  1  run in progress
- done  out  1  run finished; held until next start
- pass  out  1  valid when done=1; 1 iff err_count==0
- err_count  out  ADDR_W+1  mismatches in current/last run
- err_addr  out  ADDR_W  index of first mismatch
- err_got  out  RESP_W  DUT value at first mismatch
- err_exp  out  RESP_W  expected value at first mismatch

Behaviour:
- Reset (async, any state, including mid-run):
  - state=IDLE; stim, busy, done, pass, err_* and internal counters all 0.
  - Memory contents are not reset.
- States:
  - IDLE: busy=0, done=0.
    - start with clamped num_vec>0: idx<=0, clear err_count/err_addr/err_got/err_exp -> LOAD.
    - start with num_vec==0: -> DONE with pass=1, err_count=0.
  - LOAD: stim<=mem_stim[idx]; settle counter<=0 -> WAIT.
  - WAIT: counter increments each cycle; after SETTLE cycles in WAIT -> CHECK.
  - CHECK: sample resp and compare to mem_exp[idx].
    - On mismatch: err_count++.
    - If this is the first mismatch: capture err_addr=idx, err_got=resp, err_exp=expected.
    - Next state: mismatch && stop_on_err -> DONE; else idx==num_vec-1 -> DONE; else idx++ -> LOAD.
  - DONE: busy=0, done=1, pass=(err_count==0).
    - start: restart exactly as from IDLE; done drops the cycle after start.
- busy=1 in LOAD, WAIT and CHECK.
- Timing: each vector takes SETTLE+2 cycles. A full run of N vectors with no stop takes N*(SETTLE+2) cycles from the start cycle to done=1.
- stim holds its last value between vectors and after DONE; it is never driven combinationally from memory.
- start while busy=1: ignored.
- wr_en while busy=1: ignored; the memory is unchanged.
- wr_en in the same cycle as start from IDLE: the write takes effect and the start is accepted. The written entry is used only if it is read in a later LOAD.
- num_vec is sampled at start and held for the whole run; later changes have no effect.
- stop_on_err is sampled live in CHECK.
- err_count cannot overflow, since it is bounded by DEPTH.

Decomposition:
- Shared package: state encoding constants (IDLE, LOAD, WAIT, CHECK, DONE), default widths, and the SETTLE default.
- Sub-module vector_mem:
  - DEPTH x (STIM_W+RESP_W) register array.
  - Synchronous write port, asynchronous read port.
  - Instantiated once.
- FSM, counters and error-capture logic stay in vector_checker.

Test Plan:
- XOR truth table: load vectors {00->0, 01->1, 10->1, 11->0}, num_vec=4, DUT = s[1]^s[0], start -> done after 4*(SETTLE+2)=28 cycles, pass=1, err_count=0; stim sequence 00,01,10,11.
- Injected fault with stop_on_err=0: same memory but entry 2 expects 0 -> done at 28 cycles, pass=0, err_count=1, err_addr=2, err_got=1, err_exp=0.
- Stop on error: entries 1 and 3 wrong, stop_on_err=1 -> done 14 cycles after start, err_count=1, err_addr=1, stim holds 01.
- Boundaries: num_vec=0 -> done=1, pass=1 on the cycle after start, busy never asserted; num_vec=31 with DEPTH=16 -> run is clamped to 16 vectors.
- Reset mid-run: assert reset during WAIT of vector 2 -> all outputs 0 immediately (asynchronous); a new start then re-runs from vector 0 and passes.
- Protection: start and wr_en pulsed while busy=1 -> no restart, memory unchanged, results identical to the undisturbed run.
